// File: rtl/stack_spill.sv
// Spill/fill engine for the bottom of a J1-style register stack: on-chip window plus single-outstanding RAM port.
// Optional feature: define STACK_SPILL_DEPTH_EN to add the registered total-depth output `depth`.
module stack_spill #(
    parameter int WIDTH    = 16,
    parameter int WINDOW   = 8,
    parameter int ADDR_W   = 10,
    parameter int HI_WATER = 6,
    parameter int LO_WATER = 2
) (
    input  logic              clk,
    input  logic              resetq,
    output logic [WIDTH-1:0]  rd,
    input  logic              we,
    input  logic [1:0]        delta,
    input  logic [WIDTH-1:0]  wd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              ovf,
    output logic              unf
`ifdef STACK_SPILL_DEPTH_EN
    ,
    output logic [ADDR_W:0]   depth
`endif
);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int TAIL  = WINDOW - 1;
    localparam logic [CNT_W-1:0]  WIN_C    = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0]  HI_C     = CNT_W'(HI_WATER);
    localparam logic [CNT_W-1:0]  LO_C     = CNT_W'(LO_WATER);
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
    localparam logic [ADDR_W:0]   CAP      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [WIDTH-1:0]  EMPTY_RD = WIDTH'(16'h55aa);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPILL = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_head;
    logic [WIDTH-1:0]  r_tail [TAIL];
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W:0]   r_mem_sp;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WIDTH-1:0]  r_mem_wdata;
    logic              r_ovf;
    logic              r_unf;

    logic              w_push;
    logic              w_pop;
    logic              w_ack;
    logic              w_ram_full;
    logic              w_ram_empty;
    logic              w_push_stall;
    logic              w_pop_stall;
    logic [WIDTH-1:0]  w_bottom;
    logic [WIDTH-1:0]  w_head_n;
    logic [WIDTH-1:0]  w_tail_n [TAIL];
    logic [CNT_W-1:0]  w_count_n;
    logic [ADDR_W:0]   w_mem_sp_n;
    logic              w_ovf_n;
    logic              w_unf_n;

    assign w_push       = (delta == 2'b01);
    assign w_pop        = (delta == 2'b11);
    assign w_ack        = mem_ack && (r_state != S_IDLE);
    assign w_ram_full   = (r_mem_sp == CAP);
    assign w_ram_empty  = (r_mem_sp == '0);
    assign w_push_stall = (r_count == WIN_C && !w_ram_full) ||
                          (r_state == S_FILL && r_count == WIN_C - ONE_C);
    assign w_pop_stall  = (r_state == S_SPILL) || (r_count == ONE_C && !w_ram_empty);
    assign stall        = (w_push && w_push_stall) || (w_pop && w_pop_stall);

    // Tail slot 0 sits just below the head; the oldest entry is slot count-2.
    always_comb begin
        w_bottom = r_head;
        for (int i = 0; i < TAIL; i++)
            if (i == int'(r_count) - 2) w_bottom = r_tail[i];
    end

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        w_head_n   = r_head;
        w_tail_n   = r_tail;
        w_count_n  = r_count;
        w_mem_sp_n = r_mem_sp;
        w_ovf_n    = r_ovf;
        w_unf_n    = r_unf;
        if (!stall) begin
            if (w_push) begin
                for (int i = TAIL - 1; i > 0; i--) w_tail_n[i] = r_tail[i-1];
                w_tail_n[0] = r_head;
                if (we) w_head_n = wd;
                if (r_count == WIN_C) w_ovf_n = 1'b1;
                else                  w_count_n = r_count + ONE_C;
            end else if (w_pop) begin
                if (r_count == '0) begin
                    w_unf_n = 1'b1;
                end else begin
                    for (int i = 0; i < TAIL - 1; i++) w_tail_n[i] = r_tail[i+1];
                    w_head_n  = we ? wd : r_tail[0];
                    w_count_n = r_count - ONE_C;
                end
            end else if (we) begin
                w_head_n = wd;
            end
        end
        // RAM completion lands on top of whatever the CPU op did this edge.
        if (w_ack) begin
            if (r_state == S_SPILL) begin
                if (w_count_n != '0) w_count_n = w_count_n - ONE_C;
                w_mem_sp_n = r_mem_sp + 1'b1;
            end else begin
                if (w_count_n == '0) w_head_n = mem_rdata;
                for (int i = 0; i < TAIL; i++)
                    if (i == int'(w_count_n) - 1) w_tail_n[i] = mem_rdata;
                w_count_n  = w_count_n + ONE_C;
                w_mem_sp_n = r_mem_sp - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_count     <= '0;
            r_mem_sp    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_head   <= w_head_n;
            r_count  <= w_count_n;
            r_mem_sp <= w_mem_sp_n;
            r_ovf    <= w_ovf_n;
            r_unf    <= w_unf_n;
            case (r_state)
                S_IDLE: begin
                    if (r_count >= HI_C && !w_ram_full) begin
                        r_state     <= S_SPILL;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_mem_sp[ADDR_W-1:0];
                        r_mem_wdata <= w_bottom;
                    end else if (r_count <= LO_C && !w_ram_empty) begin
                        r_state    <= S_FILL;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_mem_sp[ADDR_W-1:0] - 1'b1;
                    end
                end
                default: if (mem_ack) r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the tail window is not reset; slots above the live count are never observed.
    always_ff @(posedge clk) r_tail <= w_tail_n;

`ifdef STACK_SPILL_DEPTH_EN
    logic [ADDR_W:0] r_depth;
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) r_depth <= '0;
        else         r_depth <= (ADDR_W+1)'(w_count_n) + w_mem_sp_n;
    end
    assign depth = r_depth;
`endif

    assign rd        = (r_count == '0) ? EMPTY_RD : r_head;
    assign mem_req   = (r_state != S_IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
endmodule
